// File: rtl/jtframe_dump_pkg.sv
// Shared definitions for the frame-dump trigger: state encoding and counter width.
package jtframe_dump_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/jtframe_edge.sv
// Registers a single-bit input and reports its rising/falling edges relative
// to the registered copy. RST_VAL chooses the sample value held in reset so
// that the release from reset can be made edge-free for the expected idle level.
module jtframe_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  // Previous-cycle sample of the input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= din;
  end

  assign rise = din & ~q;
  assign fall = q & ~din;

endmodule

// File: rtl/jtframe_dump_trig.sv
// Frame-dump trigger: counts frames (vs falling edges) after a ROM download
// finishes and opens a dump window from frame START for LENGTH frames
// (LENGTH==0 keeps the window open indefinitely). A new download aborts
// everything and returns to idle.
module jtframe_dump_trig
  import jtframe_dump_pkg::*;
#(
  parameter logic [CNT_W-1:0] START  = '0,
  parameter logic [CNT_W-1:0] LENGTH = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             dwnld,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             frame_stb,
  output logic             dump_en,
  output logic             dump_start,
  output logic             dump_stop,
  output logic [1:0]       st
);

  logic vs_l, vs_rise, vs_fall;
  logic dl_l, dl_rise, dl_fall;

  // vs idles high, so its sample resets high; dwnld idles low
  jtframe_edge #(.RST_VAL(1'b1)) u_vs (
    .clk  (clk),
    .rst  (rst),
    .din  (vs),
    .q    (vs_l),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  jtframe_edge #(.RST_VAL(1'b0)) u_dl (
    .clk  (clk),
    .rst  (rst),
    .din  (dwnld),
    .q    (dl_l),
    .rise (dl_rise),
    .fall (dl_fall)
  );

  // The registered samples and vs rise are exposed by the edge cells for debug only
  logic unused_edge;
  assign unused_edge = &{1'b0, vs_l, vs_rise, dl_l};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] win_q, win_nxt, win_inc;
  logic             stb_q, stb_nxt;
  logic             en_q, en_nxt;
  logic             start_q, start_nxt;
  logic             stop_q, stop_nxt;
  logic             frame_ev;

  assign cnt_inc  = cnt_q + 1'b1;
  assign win_inc  = win_q + 1'b1;
  // A download in progress always suppresses frame counting
  assign frame_ev = vs_fall & ~dwnld & (state != ST_IDLE);

  // State, counters and the registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      stb_q   <= 1'b0;
      en_q    <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_q   <= cnt_nxt;
      win_q   <= win_nxt;
      stb_q   <= stb_nxt;
      en_q    <= en_nxt;
      start_q <= start_nxt;
      stop_q  <= stop_nxt;
    end
  end

  // Next-state logic; pulses are computed together with the dump_en change
  // so they land on the same clock edge as the transition
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    win_nxt   = win_q;
    stb_nxt   = 1'b0;
    en_nxt    = en_q;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;

    if (dl_rise) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      win_nxt   = '0;
      en_nxt    = 1'b0;
      stop_nxt  = en_q;
    end else begin
      if (frame_ev) begin
        cnt_nxt = cnt_inc;
        stb_nxt = 1'b1;
      end
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if (dl_fall) begin
            if (START == '0) begin
              state_nxt = ST_DUMP;
              en_nxt    = 1'b1;
              start_nxt = 1'b1;
              win_nxt   = '0;
            end else begin
              state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Only an exact hit on START opens the window, even after a wrap
          if (frame_ev && cnt_inc == START) begin
            state_nxt = ST_DUMP;
            en_nxt    = 1'b1;
            start_nxt = 1'b1;
            win_nxt   = '0;
          end
        end
        ST_DUMP: begin
          if (frame_ev) begin
            win_nxt = win_inc;
            if (LENGTH != '0 && win_inc == LENGTH) begin
              state_nxt = ST_DONE;
              en_nxt    = 1'b0;
              stop_nxt  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_cnt  = cnt_q;
  assign frame_stb  = stb_q;
  assign dump_en    = en_q;
  assign dump_start = start_q;
  assign dump_stop  = stop_q;
  assign st         = state;

endmodule

// File: tb/tb_jtframe_dump_trig.sv
// Directed bench for jtframe_dump_trig: two instances (START=0/LENGTH=0 and
// START=5/LENGTH=2) share clock, reset and inputs.
module tb_jtframe_dump_trig;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b1;
  logic        dwnld = 1'b0;

  logic [31:0] f0_cnt, f5_cnt;
  logic        f0_stb, f5_stb;
  logic        en0, en5, start0, start5, stop0, stop5;
  logic [1:0]  st0, st5;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  jtframe_dump_trig #(.START(32'd0), .LENGTH(32'd0)) dut0 (
    .clk(clk), .rst(rst), .vs(vs), .dwnld(dwnld),
    .frame_cnt(f0_cnt), .frame_stb(f0_stb), .dump_en(en0),
    .dump_start(start0), .dump_stop(stop0), .st(st0)
  );

  jtframe_dump_trig #(.START(32'd5), .LENGTH(32'd2)) dut5 (
    .clk(clk), .rst(rst), .vs(vs), .dwnld(dwnld),
    .frame_cnt(f5_cnt), .frame_stb(f5_stb), .dump_en(en5),
    .dump_start(start5), .dump_stop(stop5), .st(st5)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; vs = 1'b1; dwnld = 1'b0;
    repeat (2) tick();
    total_cnt++;
    if ({f0_cnt, f0_stb, en0, start0, stop0, st0} !== 38'd0) $display("FAIL reset_dut0: got cnt=%h en=%b st=%0d required all zero", f0_cnt, en0, st0);
    else pass_cnt++;
    total_cnt++;
    if ({f5_cnt, f5_stb, en5, start5, stop5, st5} !== 38'd0) $display("FAIL reset_dut5: got cnt=%h en=%b st=%0d required all zero", f5_cnt, en5, st5);
    else pass_cnt++;
    rst = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (st0 !== 2'd0 || f0_cnt !== 32'd0 || f0_stb !== 1'b0 || start0 !== 1'b0) $display("FAIL reset_release: got st=%0d cnt=%h stb=%b start=%b required idle zeros", st0, f0_cnt, f0_stb, start0);
    else pass_cnt++;
  endtask

  task automatic test_start0;
    dwnld = 1'b1; tick();
    dwnld = 1'b0; tick();
    total_cnt++;
    if (start0 !== 1'b1 || en0 !== 1'b1 || st0 !== 2'd2) $display("FAIL start0_open: got start=%b en=%b st=%0d required 1 1 2", start0, en0, st0);
    else pass_cnt++;
    total_cnt++;
    if (st5 !== 2'd1 || start5 !== 1'b0) $display("FAIL start5_wait: got st=%0d start=%b required 1 0", st5, start5);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (start0 !== 1'b0 || en0 !== 1'b1) $display("FAIL start0_width: got start=%b en=%b required 0 1", start0, en0);
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      vs = 1'b0; tick();
      total_cnt++;
      if (f0_stb !== 1'b1 || f0_cnt !== 32'(i) || f5_cnt !== 32'(i) || start5 !== 1'b0) $display("FAIL count_%0d: got stb=%b cnt0=%h cnt5=%h start5=%b required 1 %h %h 0", i, f0_stb, f0_cnt, f5_cnt, start5, i, i);
      else pass_cnt++;
      vs = 1'b1; tick();
      total_cnt++;
      if (f0_stb !== 1'b0) $display("FAIL stb_width_%0d: got %b required 0", i, f0_stb);
      else pass_cnt++;
    end
    total_cnt++;
    if (en0 !== 1'b1 || st0 !== 2'd2) $display("FAIL start0_hold: got en=%b st=%0d required 1 2", en0, st0);
    else pass_cnt++;
  endtask

  task automatic test_window;
    for (int i = 4; i <= 8; i++) begin
      vs = 1'b0; tick();
      total_cnt++;
      if (start5 !== (i == 5) || stop5 !== (i == 7) || en5 !== (i >= 5 && i < 7) || f5_cnt !== 32'(i))
        $display("FAIL window_frame_%0d: got start=%b stop=%b en=%b cnt=%h required %b %b %b %h", i, start5, stop5, en5, f5_cnt, (i == 5), (i == 7), (i >= 5 && i < 7), i);
      else pass_cnt++;
      vs = 1'b1; tick();
      total_cnt++;
      if (start5 !== 1'b0 || stop5 !== 1'b0) $display("FAIL window_pulse_width_%0d: got start=%b stop=%b required 0 0", i, start5, stop5);
      else pass_cnt++;
    end
    total_cnt++;
    if (f5_cnt !== 32'd8 || st5 !== 2'd3 || en5 !== 1'b0) $display("FAIL window_done: got cnt=%h st=%0d en=%b required 8 3 0", f5_cnt, st5, en5);
    else pass_cnt++;
    total_cnt++;
    if (f0_cnt !== 32'd8 || en0 !== 1'b1) $display("FAIL unlimited_window: got cnt=%h en=%b required 8 1", f0_cnt, en0);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hFFFF_FFFF; exp_w[1] = 32'h0; exp_w[2] = 32'h1;
    dwnld = 1'b1; tick();
    total_cnt++;
    if (stop0 !== 1'b1 || en0 !== 1'b0 || st0 !== 2'd0 || f0_cnt !== 32'd0) $display("FAIL dl_abort_dut0: got stop=%b en=%b st=%0d cnt=%h required 1 0 0 0", stop0, en0, st0, f0_cnt);
    else pass_cnt++;
    total_cnt++;
    if (stop5 !== 1'b0 || st5 !== 2'd0 || f5_cnt !== 32'd0) $display("FAIL dl_abort_done: got stop=%b st=%0d cnt=%h required 0 0 0", stop5, st5, f5_cnt);
    else pass_cnt++;
    dwnld = 1'b0; tick();
    vs = 1'b0; tick();
    vs = 1'b1; tick();
    force dut5.cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut5.cnt_q;
    #1;
    total_cnt++;
    if (f5_cnt !== 32'hFFFF_FFFE || st5 !== 2'd1) $display("FAIL wrap_preload: got cnt=%h st=%0d required fffffffe 1", f5_cnt, st5);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      vs = 1'b0; tick();
      total_cnt++;
      if (f5_cnt !== exp_w[i] || start5 !== 1'b0 || st5 !== 2'd1) $display("FAIL wrap_step_%0d: got cnt=%h start=%b st=%0d required %h 0 1", i, f5_cnt, start5, st5, exp_w[i]);
      else pass_cnt++;
      vs = 1'b1; tick();
    end
    for (int i = 2; i <= 5; i++) begin
      vs = 1'b0; tick();
      total_cnt++;
      if (start5 !== (i == 5) || f5_cnt !== 32'(i)) $display("FAIL post_wrap_match_%0d: got start=%b cnt=%h required %b %h", i, start5, f5_cnt, (i == 5), i);
      else pass_cnt++;
      vs = 1'b1; tick();
    end
  endtask

  task automatic test_collision;
    vs = 1'b0; dwnld = 1'b1; tick();
    total_cnt++;
    if (f0_stb !== 1'b0 || stop0 !== 1'b1 || en0 !== 1'b0 || f0_cnt !== 32'd0 || st0 !== 2'd0)
      $display("FAIL collision_dut0: got stb=%b stop=%b en=%b cnt=%h st=%0d required 0 1 0 0 0", f0_stb, stop0, en0, f0_cnt, st0);
    else pass_cnt++;
    total_cnt++;
    if (f5_stb !== 1'b0 || stop5 !== 1'b1 || st5 !== 2'd0) $display("FAIL collision_dut5: got stb=%b stop=%b st=%0d required 0 1 0", f5_stb, stop5, st5);
    else pass_cnt++;
    vs = 1'b1; dwnld = 1'b0; tick();
    total_cnt++;
    if (stop0 !== 1'b0 || start0 !== 1'b1 || en0 !== 1'b1 || f0_cnt !== 32'd0) $display("FAIL collision_reopen: got stop=%b start=%b en=%b cnt=%h required 0 1 1 0", stop0, start0, en0, f0_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_dump;
    tick();
    rst = 1'b1;
    #2;
    total_cnt++;
    if ({f0_cnt, f0_stb, en0, start0, stop0, st0} !== 38'd0) $display("FAIL async_reset: got cnt=%h en=%b stop=%b st=%0d required all zero", f0_cnt, en0, stop0, st0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (stop0 !== 1'b0 || en0 !== 1'b0) $display("FAIL reset_no_stop: got stop=%b en=%b required 0 0", stop0, en0);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (st0 !== 2'd0 || stop0 !== 1'b0 || en0 !== 1'b0) $display("FAIL reset_release_idle: got st=%0d stop=%b en=%b required 0 0 0", st0, stop0, en0);
    else pass_cnt++;
  endtask

  task automatic test_vs_low_reset;
    rst = 1'b1; vs = 1'b0; tick();
    rst = 1'b0; tick();
    dwnld = 1'b1; tick();
    dwnld = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (f0_cnt !== 32'd0 || f0_stb !== 1'b0) $display("FAIL vs_low_hold_%0d: got cnt=%h stb=%b required 0 0", i, f0_cnt, f0_stb);
      else pass_cnt++;
    end
    vs = 1'b1; tick();
    total_cnt++;
    if (f0_cnt !== 32'd0) $display("FAIL vs_rise_nocount: got cnt=%h required 0", f0_cnt);
    else pass_cnt++;
    vs = 1'b0; tick();
    total_cnt++;
    if (f0_cnt !== 32'd1 || f0_stb !== 1'b1) $display("FAIL vs_genuine_fall: got cnt=%h stb=%b required 1 1", f0_cnt, f0_stb);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_start0();
    test_window();
    test_wrap();
    test_collision();
    test_reset_mid_dump();
    test_vs_low_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/jtframe_dump_trig.md
JTFRAME_DUMP_TRIG -- requirements
Module: jtframe_dump_trig

Interface
REQ-001 SHALL have parameter START, default 0: frame number at which the dump window opens.
REQ-002 SHALL have parameter LENGTH, default 0: number of frames in the dump window; 0 means unlimited.
REQ-003 SHALL have port clk  input  1  single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port vs  input  1  vertical sync, clk domain; a falling edge marks a frame boundary.
REQ-006 SHALL have port dwnld  input  1  ROM-download-in-progress flag, active high.
REQ-007 SHALL have port frame_cnt  output  32  frames elapsed since the last download end.
REQ-008 SHALL have port frame_stb  output  1  one-cycle pulse per counted frame boundary.
REQ-009 SHALL have port dump_en  output  1  high while the dump window is open.
REQ-010 SHALL have port dump_start  output  1  one-cycle pulse when dump_en rises.
REQ-011 SHALL have port dump_stop  output  1  one-cycle pulse when dump_en falls.
REQ-012 SHALL have port st  output  2  current FSM state, for debug.

Function
REQ-013 SHALL register vs and dwnld into vs_l and dl_l; vs falling edge = vs_l & ~vs; dwnld falling edge = dl_l & ~dwnld.
REQ-014 SHALL implement FSM states: IDLE=0, WAIT=1, DUMP=2, DONE=3.
REQ-015 IDLE: frame_cnt held at 0; on a dwnld falling edge go to DUMP if START==0, else go to WAIT.
REQ-016 While dwnld is low and the state is not IDLE, each vs falling edge SHALL increment frame_cnt and assert frame_stb on the same clock edge, so both are visible the cycle after the edge is sampled.
REQ-017 frame_cnt SHALL wrap from 0xFFFFFFFF to 0 without any side effect.
REQ-018 WAIT: when an increment makes frame_cnt equal START, go to DUMP on that same edge.
REQ-019 DUMP: dump_en=1; an internal 32-bit window counter, cleared on DUMP entry, SHALL increment with each frame_stb.
REQ-020 DUMP: if LENGTH!=0 and the window counter reaches LENGTH, go to DONE and clear dump_en.
REQ-021 DONE: hold state; frame_cnt keeps counting; dump_en stays 0.
REQ-022 A dwnld rising edge in any state SHALL force IDLE and clear frame_cnt; if dump_en was 1, dump_stop SHALL pulse.
REQ-023 If a vs falling edge and dwnld=1 occur in the same cycle, dwnld SHALL win: no increment and no frame_stb.
REQ-024 dump_start/dump_stop SHALL be exactly one cycle wide, registered, and coincident with the dump_en transition.
REQ-025 A START value already passed (e.g. after a wrap) SHALL be matched only on an exact equality event.

Reset
REQ-026 On rst: state=IDLE; frame_cnt=0; window counter=0; frame_stb, dump_en, dump_start, dump_stop = 0.
REQ-027 On rst: vs_l=1 and dl_l=0, so release from reset creates no spurious edge.
REQ-028 Reset asserted mid-DUMP SHALL clear dump_en with no dump_stop pulse.

Structure
REQ-029 SHALL place the state encoding and the 32-bit counter width constant in shared package jtframe_dump_pkg.
REQ-030 SHALL instantiate sub-module jtframe_edge twice, once for vs and once for dwnld; each instance provides the registered sample plus rise/fall pulses, with a parameterised reset value.

Verification
REQ-031 START=0, LENGTH=0: dwnld 1->0, then 3 vs falls -> dump_start 1 cycle after the dwnld fall; frame_cnt=3; dump_en stays 1.
REQ-032 START=5, LENGTH=2: after download, 8 vs falls -> dump_start with frame 5; dump_stop with frame 7; frame_cnt=8; st=DONE.
REQ-033 Force frame_cnt to 0xFFFFFFFE in WAIT, then 3 vs falls -> frame_cnt=1; no dump_start unless START is in {0xFFFFFFFF, 0, 1}.
REQ-034 In DUMP, raise dwnld in the same cycle as a vs fall -> no frame_stb; dump_stop pulses; frame_cnt=0; st=IDLE.
REQ-035 Assert rst mid-DUMP -> all outputs 0 immediately (asynchronously); no dump_stop; st=IDLE after release.
REQ-036 Hold vs low across reset release -> frame_cnt stays 0 until a genuine high->low transition.
